// File: rtl/mem_req_pkg.sv
// Shared types for the core-side memory initiator and the global memory controller core1_* port.
// Also defines the `ASSERT_KNOWN X-check macro used on block inputs.
package mem_req_pkg;
    localparam int addr_width = 32;
    localparam int data_width = 32;
    // Widest tag the request queue carries; the initiator's TAG_WIDTH must not exceed it.
    localparam int tag_width  = 4;

    typedef struct packed {
        logic                  wr;
        logic [addr_width-1:0] addr;
        logic [data_width-1:0] wr_data;
        logic [tag_width-1:0]  tag;
    } mem_req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} mem_init_state_e;
endpackage

`ifndef ASSERT_KNOWN
`define ASSERT_KNOWN(sig) assert property (@(posedge clk) !$isunknown(sig))
`endif

// File: rtl/mem_req_initiator_req_fifo.sv
// req_fifo: synchronous request FIFO of mem_req_t with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguished without a counter.
module req_fifo
    import mem_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  mem_req_t din,
    input  logic     pop,
    output mem_req_t dout,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    mem_req_t        mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/mem_req_initiator.sv
// mem_req_initiator: queues core load/store requests and issues them one at a time on the
// controller core1_* port, returning tagged responses. MEM_REQ_TIMEOUT_EN adds a WAIT timeout abort.
module mem_req_initiator
    import mem_req_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 4,
    parameter int TAG_WIDTH      = tag_width,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [addr_width-1:0] req_addr,
    input  logic [data_width-1:0] req_wr_data,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_wr,
    output logic [data_width-1:0] resp_data,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic                  resp_err,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wr_data,
    input  logic                  mem_busy,
    input  logic                  mem_ack,
    input  logic [data_width-1:0] mem_rd_data
);
    mem_init_state_e      state, state_nxt;
    mem_req_t             in_req, head;
    logic                 full, empty;
    logic                 pop, capture, abort;
    logic                 cur_wr;
    logic [TAG_WIDTH-1:0] cur_tag;
    logic                 timed_out;
    logic                 ack_stray_ok;

    assign in_req    = '{wr: req_wr, addr: req_addr, wr_data: req_wr_data, tag: tag_width'(req_tag)};
    assign req_ready = !full;

    req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid),
        .din   (in_req),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            // The single response slot must be free before another request goes out.
            IDLE:  if (!empty && !resp_valid) begin
                       pop       = 1'b1;
                       state_nxt = ISSUE;
                   end
            ISSUE: state_nxt = WAIT;
            WAIT:  if (mem_ack) begin
                       capture   = 1'b1;
                       state_nxt = IDLE;
                   end else if (timed_out) begin
                       abort     = 1'b1;
                       state_nxt = IDLE;
                   end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            cur_wr      <= 1'b0;
            cur_tag     <= '0;
            resp_valid  <= 1'b0;
            resp_wr     <= 1'b0;
            resp_data   <= '0;
            resp_tag    <= '0;
        end else begin
            mem_rd_req <= pop && !head.wr;
            mem_wr_req <= pop && head.wr;
            if (pop) begin
                mem_addr    <= head.addr;
                mem_wr_data <= head.wr_data;
                cur_wr      <= head.wr;
                cur_tag     <= TAG_WIDTH'(head.tag);
            end
            if (resp_valid && resp_ready)
                resp_valid <= 1'b0;
            if (capture || abort) begin
                resp_valid <= 1'b1;
                resp_wr    <= cur_wr;
                resp_tag   <= cur_tag;
                resp_data  <= (capture && !cur_wr) ? mem_rd_data : '0;
            end
        end
    end

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt;
    logic          abandoned;

    // wait_cnt counts completed WAIT cycles; the abort lands after TIMEOUT_CYCLES of them.
    assign timed_out    = (wait_cnt == CNT_LAST);
    assign ack_stray_ok = abandoned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            abandoned <= 1'b0;
            resp_err  <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + CW'(1) : '0;
            if (abort)        abandoned <= 1'b1;
            else if (capture) abandoned <= 1'b0;
            if (capture || abort)
                resp_err <= abort;
        end
    end
`else
    assign timed_out    = 1'b0;
    assign ack_stray_ok = 1'b0;
    assign resp_err     = 1'b0;
`endif

    `ASSERT_KNOWN(rst);
    `ASSERT_KNOWN(req_valid);
    `ASSERT_KNOWN(mem_ack);
    `ASSERT_KNOWN(resp_ready);

    a_ack_in_wait: assert property (@(posedge clk) disable iff (!rst)
        mem_ack |-> (state == WAIT || ack_stray_ok));
    a_busy_issue: assert property (@(posedge clk) disable iff (!rst)
        (state == ISSUE) |-> !mem_busy);
    a_req_excl: assert property (@(posedge clk) disable iff (!rst)
        !(mem_rd_req && mem_wr_req));
endmodule

// File: tb/tb_mem_req_initiator.sv
// Bench for mem_req_initiator: behavioural controller (delay D) plus a queue scoreboard with a
// forked monitor that checks every accepted response against hand-computed expectations.
module tb_mem_req_initiator;
    import mem_req_pkg::*;

    localparam int D  = 5;
    localparam int TW = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  req_valid = 1'b0, req_wr = 1'b0;
    logic                  req_ready;
    logic [addr_width-1:0] req_addr = '0;
    logic [data_width-1:0] req_wr_data = '0;
    logic [TW-1:0]         req_tag = '0;
    logic                  resp_valid, resp_wr, resp_err;
    logic                  resp_ready = 1'b1;
    logic [data_width-1:0] resp_data;
    logic [TW-1:0]         resp_tag;
    logic                  mem_rd_req, mem_wr_req;
    logic [addr_width-1:0] mem_addr;
    logic [data_width-1:0] mem_wr_data;
    logic                  mem_busy, mem_ack;
    logic [data_width-1:0] mem_rd_data;

    logic noack = 1'b0, stray_ack = 1'b0;

    mem_req_initiator #(.QUEUE_DEPTH(4), .TAG_WIDTH(TW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wr_data(req_wr_data), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_wr(resp_wr),
        .resp_data(resp_data), .resp_tag(resp_tag), .resp_err(resp_err),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_busy(mem_busy), .mem_ack(mem_ack),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: ack lands D edges after the request is sampled.
    logic [31:0] cmem [0:255];
    logic        pend, pend_wr;
    logic [31:0] pend_addr, pend_data;
    int          pcnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ack     <= 1'b0;
            mem_busy    <= 1'b0;
            mem_rd_data <= '0;
            pend        <= 1'b0;
            pend_wr     <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= '0;
            pcnt        <= 0;
            cmem[8'h10] <= 32'hDEADBEEF;
        end else begin
            mem_ack <= 1'b0;
            if (mem_rd_req || mem_wr_req) begin
                pend      <= 1'b1;
                mem_busy  <= 1'b1;
                pcnt      <= D - 1;
                pend_wr   <= mem_wr_req;
                pend_addr <= mem_addr;
                pend_data <= mem_wr_data;
            end else if (pend) begin
                if (pcnt == 0) begin
                    pend     <= 1'b0;
                    mem_busy <= 1'b0;
                    if (!noack) begin
                        mem_ack <= 1'b1;
                        if (pend_wr) cmem[pend_addr[9:2]] <= pend_data;
                        else         mem_rd_data <= cmem[pend_addr[9:2]];
                    end
                end else begin
                    pcnt <= pcnt - 1;
                end
            end
            if (stray_ack) mem_ack <= 1'b1;
        end
    end

    typedef struct {
        logic        wr;
        logic        err;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int pass_cnt = 0, total_cnt = 0, excl_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_rd_req && mem_wr_req) excl_bad++;
                if (resp_valid && resp_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", 64'(resp_tag), 64'hFFFF);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("resp_tag%0d", e.tag),
                              64'({resp_wr, resp_err, resp_tag, resp_data}),
                              64'({e.wr, e.err, e.tag, e.data}));
                    end
                end
            end
        end
    endtask

    // Called and returns at a negedge; t_push is the cycle count just after the transfer edge.
    task automatic push(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic [3:0] tag, input logic exp_err,
                        output int t_push);
        int n = 0;
        exp_t e;
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wr_data = wdata; req_tag = tag;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin
            check("push_ready_timeout", 64'(req_ready), 64'd1);
        end else begin
            e.wr = wr; e.err = exp_err; e.tag = tag; e.data = exp_data;
            sb.push_back(e);
            @(negedge clk);
        end
        t_push = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int t);
        int n = 0;
        while (!resp_valid && n < 200) begin @(negedge clk); n++; end
        if (!resp_valid) check("resp_wait_timeout", 64'(resp_valid), 64'd1);
        t = cyc;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 400) begin @(negedge clk); n++; end
        if (sb.size() != 0 || resp_valid) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic any_out();
        return |{mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
                 resp_valid, resp_wr, resp_data, resp_tag, resp_err};
    endfunction

    initial begin
        int t0, t1, held_bad, seen;
        fork monitor(); join_none

        // reset state
        #2;
        check("reset_outputs_zero", 64'(any_out()), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: single load, latency D+3
        push(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 4'd3, 1'b0, t0);
        wait_resp(t1);
        check("load_latency", 64'(t1 - t0), 64'(D + 3));
        drain();

        // 2: store then load back-to-back
        push(1'b1, 32'h80, 32'h12345678, 32'h0, 4'd1, 1'b0, t0);
        push(1'b0, 32'h80, 32'h0, 32'h12345678, 4'd2, 1'b0, t0);
        drain();

        // 3: five requests fill the queue behind the one in flight
        push(1'b1, 32'h100, 32'hA1, 32'h0,  4'd7,  1'b0, t0);
        push(1'b1, 32'h104, 32'hB2, 32'h0,  4'd8,  1'b0, t0);
        push(1'b0, 32'h100, 32'h0,  32'hA1, 4'd9,  1'b0, t0);
        push(1'b0, 32'h104, 32'h0,  32'hB2, 4'd10, 1'b0, t0);
        push(1'b1, 32'h108, 32'hC3, 32'h0,  4'd11, 1'b0, t0);
        check("queue_full_ready_low", 64'(req_ready), 64'd0);
        drain();

        // 4: response held under backpressure, next issue follows the release
        resp_ready = 1'b0;
        push(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 4'd5, 1'b0, t0);
        push(1'b0, 32'h80, 32'h0, 32'h12345678, 4'd6, 1'b0, t0);
        wait_resp(t1);
        held_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(resp_valid && resp_data == 32'hDEADBEEF && resp_tag == 4'd5 &&
                  !mem_rd_req && !mem_wr_req)) held_bad++;
            @(negedge clk);
        end
        check("held_resp_stable", 64'(held_bad), 64'd0);
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("no_issue_while_slot_full", 64'(mem_rd_req), 64'd0);
        @(negedge clk);
        check("issue_after_release", 64'(mem_rd_req), 64'd1);
        drain();

        // 5: reset while waiting with three queued
        push(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 4'd1, 1'b0, t0);
        push(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 4'd2, 1'b0, t0);
        push(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 4'd3, 1'b0, t0);
        push(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 4'd4, 1'b0, t0);
        rst = 1'b0;
        sb.delete();
        #1;
        check("midrun_reset_outputs_zero", 64'(any_out()), 64'd0);
        check("midrun_reset_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("no_resp_after_reset", 64'(seen), 64'd0);
        push(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 4'd9, 1'b0, t0);
        wait_resp(t1);
        check("post_reset_latency", 64'(t1 - t0), 64'(D + 3));
        drain();

`ifdef MEM_REQ_TIMEOUT_EN
        // 6: controller never acks; abort after 8 WAIT cycles, stray ack ignored
        noack = 1'b1;
        push(1'b0, 32'h40, 32'h0, 32'h0, 4'd12, 1'b1, t0);
        wait_resp(t1);
        check("timeout_latency", 64'(t1 - t0), 64'd10);
        drain();
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("stray_ack_ignored", 64'(seen), 64'd0);
        noack = 1'b0;
`endif

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("rd_wr_exclusive", 64'(excl_bad), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end
endmodule
